// File: rtl/window_pkg.sv
// Shared constants for the 5x5 window sequencer: FSM encodings and window geometry.
// No logic of its own.
package window_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] FILL = 2'd1;
   localparam logic [1:0] RUN  = 2'd2;

   localparam int WIN_K  = 5;
   localparam int WIN_M1 = WIN_K - 1;

endpackage

// File: rtl/window_5x5_sequencer_mod_counter.sv
// Wrapping up-counter 0..MAX with synchronous clear; clear and count in one cycle counts from zero.
// wrap_o is combinational and marks the count that returns q to zero.
module mod_counter #(
   parameter int MAX = 4,
   parameter int W   = (MAX < 1) ? 1 : $clog2(MAX + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   output logic         wrap_o,
   output logic [W-1:0] q
);

   logic [W-1:0] base;
   logic [W-1:0] q_nxt;

   always_comb begin
      base   = clr ? '0 : q;
      wrap_o = en && (base == W'(MAX));
      q_nxt  = base;
      if (wrap_o) begin
         q_nxt = '0;
      end else if (en) begin
         q_nxt = base + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= '0;
      end else begin
         q <= q_nxt;
      end
   end

endmodule

// File: rtl/window_5x5_sequencer.sv
// Column/row sequencer for the 5x5 window datapath; window flags and coordinates one cycle after done_i.
// No backpressure: every done_i is accepted and raises count_en in the same cycle.
module window_5x5_sequencer
   import window_pkg::*;
#(
   parameter int COLS = 7,
   parameter int ROWS = 7
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    frame_start_i,
   input  logic                    done_i,
   output logic                    count_en,
   output logic                    done_o,
   output logic                    progress_done_o,
   output logic [$clog2(COLS)-1:0] win_col_o,
   output logic [$clog2(ROWS)-1:0] win_row_o,
   output logic                    busy_o
);

   localparam int CW   = $clog2(COLS);
   localparam int RW   = $clog2(ROWS);
   localparam int RMAX = ROWS - WIN_K;
   localparam int RCW  = (RMAX < 1) ? 1 : $clog2(RMAX + 1);

   logic [1:0]     state;
   logic [1:0]     state_nxt;
   logic [1:0]     st_base;
   logic [CW-1:0]  col_q;
   logic [CW-1:0]  col_base;
   logic [RCW-1:0] row_q;
   logic           col_wrap;
   logic           row_wrap;
   logic           win_fire;
   logic           last_fire;

   mod_counter #(.MAX(COLS - 1), .W(CW)) u_col (
      .clk    (clk),
      .rst    (rst),
      .clr    (frame_start_i),
      .en     (done_i),
      .wrap_o (col_wrap),
      .q      (col_q)
   );

   mod_counter #(.MAX(RMAX), .W(RCW)) u_row (
      .clk    (clk),
      .rst    (rst),
      .clr    (frame_start_i),
      .en     (col_wrap),
      .wrap_o (row_wrap),
      .q      (row_q)
   );

   // frame_start_i restarts from IDLE before the same-cycle column is applied
   assign st_base  = frame_start_i ? IDLE : state;
   assign col_base = frame_start_i ? '0 : col_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= IDLE;
         done_o          <= 1'b0;
         progress_done_o <= 1'b0;
         win_col_o       <= '0;
         win_row_o       <= '0;
         busy_o          <= 1'b0;
      end else begin
         state           <= state_nxt;
         done_o          <= win_fire;
         progress_done_o <= last_fire;
         busy_o          <= (state_nxt != IDLE);
         if (win_fire) begin
            win_col_o <= col_base - CW'(WIN_M1);
            win_row_o <= RW'(row_q);
         end
      end
   end

   always_comb begin
      state_nxt = ((st_base == FILL) || (st_base == RUN)) ? st_base : IDLE;
      if (done_i) begin
         if (col_wrap) begin
            state_nxt = row_wrap ? IDLE : FILL;
         end else if (col_base >= CW'(WIN_M1 - 1)) begin
            state_nxt = RUN;
         end else begin
            state_nxt = FILL;
         end
      end
   end

   always_comb begin
      count_en  = done_i & rst;
      win_fire  = done_i && (st_base == RUN);
      last_fire = win_fire && col_wrap && row_wrap;
   end

endmodule
